// File: rtl/sram_req_arbiter.sv
// Two-master arbiter for a shared SRAM-like bus: data-priority grant with an
// inst anti-starvation limit, grant lock until addr_ok, in-order response routing.
module sram_req_arbiter #(
  parameter int OUTSTANDING     = 4,
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic        clk,
  input  logic        resetn,

  input  logic        inst_sram_req,
  input  logic        inst_sram_wr,
  input  logic [1:0]  inst_sram_size,
  input  logic [31:0] inst_sram_addr,
  input  logic [3:0]  inst_sram_wstrb,
  input  logic [31:0] inst_sram_wdata,
  output logic        inst_sram_addr_ok,
  output logic        inst_sram_data_ok,
  output logic [31:0] inst_sram_rdata,

  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [1:0]  data_sram_size,
  input  logic [31:0] data_sram_addr,
  input  logic [3:0]  data_sram_wstrb,
  input  logic [31:0] data_sram_wdata,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata,

  output logic        out_sram_req,
  output logic        out_sram_wr,
  output logic [1:0]  out_sram_size,
  output logic [31:0] out_sram_addr,
  output logic [3:0]  out_sram_wstrb,
  output logic [31:0] out_sram_wdata,
  input  logic        out_sram_addr_ok,
  input  logic        out_sram_data_ok,
  input  logic [31:0] out_sram_rdata,

  output logic        err_unexp_ok
);

  localparam int PTR_W = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
  localparam int CNT_W = $clog2(OUTSTANDING + 1);
  localparam int STK_W = $clog2(MAX_DATA_STREAK + 1);

  typedef enum logic {
    SRC_INST = 1'b0,
    SRC_DATA = 1'b1
  } src_e;

  logic             lock_q;
  src_e             lock_src_q;
  logic [STK_W-1:0] streak_q;
  logic [CNT_W-1:0] count_q;
  logic [PTR_W-1:0] head_q;
  logic [PTR_W-1:0] tail_q;
  src_e             fifo_q [OUTSTANDING];
  logic             err_q;

  src_e gnt_src;
  logic gnt_valid;
  logic slot_free;
  logic accept;
  logic pop;
  src_e head_src;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(OUTSTANDING - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // NOTE: every signal assigned in always_comb gets a default first, otherwise
  // any path that skips an assignment infers a latch.
  always_comb begin
    gnt_src   = SRC_INST;
    gnt_valid = 1'b0;
    if (lock_q) begin
      gnt_src   = lock_src_q;
      gnt_valid = (lock_src_q == SRC_DATA) ? data_sram_req : inst_sram_req;
    end else if (data_sram_req &&
                 !(inst_sram_req && streak_q == STK_W'(MAX_DATA_STREAK))) begin
      gnt_src   = SRC_DATA;
      gnt_valid = 1'b1;
    end else if (inst_sram_req) begin
      gnt_src   = SRC_INST;
      gnt_valid = 1'b1;
    end
  end

  // Full check uses the pre-pop count: a response this cycle frees a slot next cycle.
  assign slot_free    = (count_q < CNT_W'(OUTSTANDING));
  assign out_sram_req = resetn & gnt_valid & slot_free;
  assign accept       = out_sram_req & out_sram_addr_ok;

  always_comb begin
    out_sram_wr    = 1'b0;
    out_sram_size  = 2'd0;
    out_sram_addr  = 32'd0;
    out_sram_wstrb = 4'd0;
    out_sram_wdata = 32'd0;
    if (gnt_valid) begin
      if (gnt_src == SRC_DATA) begin
        out_sram_wr    = data_sram_wr;
        out_sram_size  = data_sram_size;
        out_sram_addr  = data_sram_addr;
        out_sram_wstrb = data_sram_wstrb;
        out_sram_wdata = data_sram_wdata;
      end else begin
        out_sram_wr    = inst_sram_wr;
        out_sram_size  = inst_sram_size;
        out_sram_addr  = inst_sram_addr;
        out_sram_wstrb = inst_sram_wstrb;
        out_sram_wdata = inst_sram_wdata;
      end
    end
  end

  assign inst_sram_addr_ok = accept & (gnt_src == SRC_INST);
  assign data_sram_addr_ok = accept & (gnt_src == SRC_DATA);

  assign head_src          = fifo_q[head_q];
  assign pop               = resetn & out_sram_data_ok & (count_q != '0);
  assign inst_sram_data_ok = pop & (head_src == SRC_INST);
  assign data_sram_data_ok = pop & (head_src == SRC_DATA);
  assign inst_sram_rdata   = out_sram_rdata;
  assign data_sram_rdata   = out_sram_rdata;
  assign err_unexp_ok      = err_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lock_q     <= 1'b0;
      lock_src_q <= SRC_INST;
      streak_q   <= '0;
      count_q    <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      // Lock holds the grant only while a presented request is still waiting;
      // it drops on acceptance or when the locked requester withdraws.
      lock_q <= out_sram_req & ~out_sram_addr_ok;
      if (out_sram_req) lock_src_q <= gnt_src;

      case ({accept, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
      if (accept) tail_q <= next_ptr(tail_q);
      if (pop)    head_q <= next_ptr(head_q);

      if (!inst_sram_req || (accept && gnt_src == SRC_INST))
        streak_q <= '0;
      else if (accept && gnt_src == SRC_DATA && streak_q != STK_W'(MAX_DATA_STREAK))
        streak_q <= streak_q + STK_W'(1);

      if (out_sram_data_ok && count_q == '0) err_q <= 1'b1;
    end
  end

  // NOTE: the source FIFO storage is not reset; an entry is only read after it
  // has been written, and count/pointers carry all the reset state.
  always_ff @(posedge clk) begin
    if (accept) fifo_q[tail_q] <= gnt_src;
  end

endmodule

// File: tb/tb_sram_req_arbiter.sv
// Randomized bench for sram_req_arbiter against a queue-based transaction model.
module tb_sram_req_arbiter;

  localparam int OUT  = 4;
  localparam int MAXS = 4;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_sram_req, inst_sram_wr;
  logic [1:0]  inst_sram_size;
  logic [31:0] inst_sram_addr, inst_sram_wdata;
  logic [3:0]  inst_sram_wstrb;
  logic        inst_sram_addr_ok, inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;
  logic        data_sram_req, data_sram_wr;
  logic [1:0]  data_sram_size;
  logic [31:0] data_sram_addr, data_sram_wdata;
  logic [3:0]  data_sram_wstrb;
  logic        data_sram_addr_ok, data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  logic        out_sram_req, out_sram_wr;
  logic [1:0]  out_sram_size;
  logic [31:0] out_sram_addr, out_sram_wdata;
  logic [3:0]  out_sram_wstrb;
  logic        out_sram_addr_ok, out_sram_data_ok;
  logic [31:0] out_sram_rdata;
  logic        err_unexp_ok;

  sram_req_arbiter #(.OUTSTANDING(OUT), .MAX_DATA_STREAK(MAXS)) dut (
    .clk(clk), .resetn(resetn),
    .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr),
    .inst_sram_size(inst_sram_size), .inst_sram_addr(inst_sram_addr),
    .inst_sram_wstrb(inst_sram_wstrb), .inst_sram_wdata(inst_sram_wdata),
    .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok),
    .inst_sram_rdata(inst_sram_rdata),
    .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr),
    .data_sram_size(data_sram_size), .data_sram_addr(data_sram_addr),
    .data_sram_wstrb(data_sram_wstrb), .data_sram_wdata(data_sram_wdata),
    .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok),
    .data_sram_rdata(data_sram_rdata),
    .out_sram_req(out_sram_req), .out_sram_wr(out_sram_wr),
    .out_sram_size(out_sram_size), .out_sram_addr(out_sram_addr),
    .out_sram_wstrb(out_sram_wstrb), .out_sram_wdata(out_sram_wdata),
    .out_sram_addr_ok(out_sram_addr_ok), .out_sram_data_ok(out_sram_data_ok),
    .out_sram_rdata(out_sram_rdata),
    .err_unexp_ok(err_unexp_ok)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Transaction model: queue of issuers (0=inst, 1=data) awaiting a response.
  bit m_q[$];
  int m_streak;
  int m_locked;     // -1 when no request is waiting for addr_ok
  bit m_err;
  bit inst_acc, data_acc;
  int max_count;

  task automatic model_reset();
    m_q.delete();
    m_streak = 0;
    m_locked = -1;
    m_err    = 1'b0;
    inst_acc = 1'b0;
    data_acc = 1'b0;
  endtask

  // Compare one cycle's outputs against the model, then advance it at the edge.
  task automatic cycle();
    int g;
    bit gv, exp_req, pop;
    int pre_size;
    #1;
    g  = 0;
    gv = 1'b0;
    if (m_locked >= 0) begin
      g  = m_locked;
      gv = (g == 1) ? data_sram_req : inst_sram_req;
    end else if (data_sram_req && !(inst_sram_req && m_streak == MAXS)) begin
      g = 1; gv = 1'b1;
    end else if (inst_sram_req) begin
      g = 0; gv = 1'b1;
    end
    pre_size = m_q.size();
    exp_req  = gv && (pre_size < OUT);
    pop      = out_sram_data_ok && (pre_size > 0);

    check("out_req", 32'(out_sram_req), 32'(exp_req));
    check("out_addr", out_sram_addr,
          !gv ? 32'd0 : (g == 1) ? data_sram_addr : inst_sram_addr);
    check("out_wdata", out_sram_wdata,
          !gv ? 32'd0 : (g == 1) ? data_sram_wdata : inst_sram_wdata);
    check("out_ctl", {25'd0, out_sram_wr, out_sram_size, out_sram_wstrb},
          !gv ? 32'd0 : (g == 1) ? {25'd0, data_sram_wr, data_sram_size, data_sram_wstrb}
                                 : {25'd0, inst_sram_wr, inst_sram_size, inst_sram_wstrb});
    check("inst_addr_ok", 32'(inst_sram_addr_ok), 32'(exp_req && out_sram_addr_ok && g == 0));
    check("data_addr_ok", 32'(data_sram_addr_ok), 32'(exp_req && out_sram_addr_ok && g == 1));
    check("inst_data_ok", 32'(inst_sram_data_ok), 32'(pop && m_q[0] == 1'b0));
    check("data_data_ok", 32'(data_sram_data_ok), 32'(pop && m_q[0] == 1'b1));
    check("rdata", inst_sram_rdata ^ data_sram_rdata ^ out_sram_rdata, out_sram_rdata);
    check("err", 32'(err_unexp_ok), 32'(m_err));

    @(posedge clk);
    inst_acc = exp_req && out_sram_addr_ok && g == 0;
    data_acc = exp_req && out_sram_addr_ok && g == 1;
    if (pop) void'(m_q.pop_front());
    if (inst_acc || data_acc) m_q.push_back(g == 1);
    if (out_sram_data_ok && pre_size == 0) m_err = 1'b1;
    m_locked = (exp_req && !out_sram_addr_ok) ? g : -1;
    if (!inst_sram_req || inst_acc) m_streak = 0;
    else if (data_acc && m_streak < MAXS) m_streak++;
    if (m_q.size() > max_count) max_count = m_q.size();
  endtask

  task automatic gen_inputs(input int p_inst, input int p_data, input int p_aok, input int p_dok);
    if (!inst_sram_req || inst_acc) begin
      inst_sram_req   = ($urandom_range(0, 99) < p_inst);
      inst_sram_wr    = $urandom_range(0, 1);
      inst_sram_size  = 2'($urandom_range(0, 2));
      inst_sram_addr  = $urandom;
      inst_sram_wstrb = 4'($urandom);
      inst_sram_wdata = $urandom;
    end
    if (!data_sram_req || data_acc) begin
      data_sram_req   = ($urandom_range(0, 99) < p_data);
      data_sram_wr    = $urandom_range(0, 1);
      data_sram_size  = 2'($urandom_range(0, 2));
      data_sram_addr  = $urandom;
      data_sram_wstrb = 4'($urandom);
      data_sram_wdata = $urandom;
    end
    out_sram_addr_ok = ($urandom_range(0, 99) < p_aok);
    out_sram_data_ok = (m_q.size() > 0) && ($urandom_range(0, 99) < p_dok);
    out_sram_rdata   = $urandom;
  endtask

  task automatic run_phase(input int n, input int p_inst, input int p_data,
                           input int p_aok, input int p_dok);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      gen_inputs(p_inst, p_data, p_aok, p_dok);
      cycle();
    end
  endtask

  task automatic idle_inputs();
    inst_sram_req = 1'b0; inst_sram_wr = 1'b0; inst_sram_size = 2'd0;
    inst_sram_addr = 32'd0; inst_sram_wstrb = 4'd0; inst_sram_wdata = 32'd0;
    data_sram_req = 1'b0; data_sram_wr = 1'b0; data_sram_size = 2'd0;
    data_sram_addr = 32'd0; data_sram_wstrb = 4'd0; data_sram_wdata = 32'd0;
    out_sram_addr_ok = 1'b0; out_sram_data_ok = 1'b0; out_sram_rdata = 32'd0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit filled;
    idle_inputs();
    model_reset();
    max_count = 0;
    resetn = 1'b0;
    // Reset: outputs stay quiet even with every input asserted.
    inst_sram_req = 1'b1; data_sram_req = 1'b1;
    out_sram_addr_ok = 1'b1; out_sram_data_ok = 1'b1;
    #12;
    check("rst_out_req", 32'(out_sram_req), 32'd0);
    check("rst_addr_ok", {30'd0, inst_sram_addr_ok, data_sram_addr_ok}, 32'd0);
    check("rst_data_ok", {30'd0, inst_sram_data_ok, data_sram_data_ok}, 32'd0);
    check("rst_err", 32'(err_unexp_ok), 32'd0);
    @(negedge clk);
    idle_inputs();
    resetn = 1'b1;

    // Single inst read, addr_ok in cycle 1, response in cycle 3.
    @(negedge clk);
    inst_sram_req = 1'b1; inst_sram_size = 2'd2; inst_sram_addr = 32'h1C00_0000;
    #1 check("t1_addr", out_sram_addr, 32'h1C00_0000);
    cycle();
    @(negedge clk);
    out_sram_addr_ok = 1'b1;
    #1 check("t1_inst_addr_ok", 32'(inst_sram_addr_ok), 32'd1);
    cycle();
    @(negedge clk);
    inst_sram_req = 1'b0; out_sram_addr_ok = 1'b0;
    cycle();
    @(negedge clk);
    out_sram_data_ok = 1'b1; out_sram_rdata = 32'h0280_0000;
    #1 check("t1_inst_data_ok", 32'(inst_sram_data_ok), 32'd1);
    check("t1_rdata", inst_sram_rdata, 32'h0280_0000);
    check("t1_data_data_ok", 32'(data_sram_data_ok), 32'd0);
    cycle();

    // Contention, lock, full, wrap with lagging responses, then mixed traffic.
    run_phase(60, 100, 100, 100, 60);
    run_phase(80, 60, 70, 40, 50);
    run_phase(40, 80, 80, 90, 0);
    run_phase(80, 80, 80, 90, 30);
    max_count = 0;
    run_phase(60, 50, 50, 100, 100);
    run_phase(400, 50, 60, 60, 45);

    // Reset with requests outstanding.
    filled = 1'b0;
    for (int i = 0; i < 100 && !filled; i++) begin
      @(negedge clk);
      gen_inputs(90, 90, 90, 0);
      cycle();
      filled = (m_q.size() >= 2);
    end
    check("fill_before_reset", 32'(filled), 32'd1);
    @(negedge clk);
    resetn = 1'b0;
    inst_sram_req = 1'b1; data_sram_req = 1'b1;
    out_sram_addr_ok = 1'b1; out_sram_data_ok = 1'b1;
    #1;
    check("mid_rst_out_req", 32'(out_sram_req), 32'd0);
    check("mid_rst_addr_ok", {30'd0, inst_sram_addr_ok, data_sram_addr_ok}, 32'd0);
    check("mid_rst_data_ok", {30'd0, inst_sram_data_ok, data_sram_data_ok}, 32'd0);
    model_reset();
    @(negedge clk);
    idle_inputs();
    resetn = 1'b1;
    @(negedge clk);
    out_sram_data_ok = 1'b1;
    #1 check("stray_no_pulse", {30'd0, inst_sram_data_ok, data_sram_data_ok}, 32'd0);
    cycle();
    @(negedge clk);
    out_sram_data_ok = 1'b0;
    #1 check("stray_err", 32'(err_unexp_ok), 32'd1);
    cycle();
    run_phase(40, 60, 60, 70, 50);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_req_arbiter.md
Name: sram_req_arbiter

Overview:
Shares one SRAM-like bus (towards the AXI bridge) between the IF-stage instruction port and the MEM-stage data port. Accepts requests with data priority and an anti-starvation limit. Holds the grant stable while a request waits for addr_ok. Tracks accepted requests in an in-order source FIFO so each downstream data_ok/rdata goes back to the requester that issued it.

Parameters:
OUTSTANDING, 4, maximum accepted-but-unanswered requests (power of 2, 2..16)
MAX_DATA_STREAK, 4, consecutive data grants allowed while inst_req is waiting before inst wins one grant

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
inst_sram_req/wr  in  1/1  IF request, write flag
inst_sram_size  in  2  0=byte 1=half 2=word
inst_sram_addr/wstrb/wdata  in  32/4/32  IF address, byte strobes, write data
inst_sram_addr_ok/data_ok  out  1/1  IF request accepted / response
inst_sram_rdata  out  32  IF read data
data_sram_req/wr/size/addr/wstrb/wdata  in  1/1/2/32/4/32  MEM-side request, same meaning
data_sram_addr_ok/data_ok/rdata  out  1/1/32  MEM-side handshake and read data
out_sram_req/wr/size/addr/wstrb/wdata  out  1/1/2/32/4/32  muxed downstream request
out_sram_addr_ok/data_ok  in  1/1  downstream accept / response (reads and writes)
out_sram_rdata  in  32  downstream read data
err_unexp_ok  out  1  sticky: out_sram_data_ok arrived while the FIFO was empty

Behaviour:
- Reset (resetn=0, async): FIFO empty, count=0, lock=0, streak=0, err_unexp_ok=0. All req/addr_ok/data_ok outputs are 0 while resetn=0.
- Grant selection (combinational, when lock=0):
  - data wins if data_sram_req and not (inst_sram_req and streak==MAX_DATA_STREAK).
  - Otherwise inst wins if inst_sram_req.
- out_sram_req = (granted requester's req) & (count<OUTSTANDING). Blocking uses the count before this cycle's pop; a same-cycle pop does not free a slot.
- out_sram_wr/size/addr/wstrb/wdata mux from the granted source. They are driven 0 when there is no grant.
- Lock:
  - If out_sram_req=1 and out_sram_addr_ok=0, register lock=1 and lock_src=granted source.
  - While lock=1, grant is forced to lock_src regardless of priority.
  - Lock clears on the cycle addr_ok is sampled with out_sram_req=1.
  - Requesters must hold req and payload until addr_ok. The arbiter does not mask a lock_src deassert: req simply drops and lock clears.
- addr_ok routing: out_sram_addr_ok & out_sram_req goes only to the granted source. The other source sees addr_ok=0.
- Accept (req&addr_ok): push source ID (0=inst, 1=data) into the FIFO, count+1.
- Streak: data accepted while inst_sram_req=1 gives streak+1, saturating at MAX_DATA_STREAK. Inst accepted, or inst_sram_req=0, resets streak to 0.
- Response: out_sram_data_ok with count>0 pops the head and pulses data_ok for that source in the same cycle (combinational). rdata passes through to both rdata outputs unconditionally.
- Same-cycle push and pop: count unchanged, head and tail pointers both advance. Pointers wrap modulo OUTSTANDING.
- out_sram_data_ok with count==0: ignored (no data_ok pulse, no count change), err_unexp_ok=1 until reset.
- Downstream guarantee: data_ok for a request never comes in the cycle it is accepted. Responses return in acceptance order.
- Latency: zero added cycles on request and on response paths.

Test Plan:
- Single inst read: inst_req addr=0x1C000000, addr_ok at cycle 1, downstream data_ok at cycle 3 with rdata=0x02800000 -> out_sram_addr=0x1C000000 at cycle 0; inst_addr_ok at 1; inst_data_ok=1 with rdata at 3; data_data_ok stays 0.
- Contention: inst_req and data_req both high, addr_ok every cycle -> data granted for 4 accepts, then 1 inst grant, then data again. FIFO order D,D,D,D,I; responses return to matching ports.
- Lock: data_req alone, addr_ok held low 3 cycles; inst_req rises in cycle 1 -> out_sram_addr stays the data address through cycle 3; inst_addr_ok=0 until data is accepted.
- Full: 4 accepts with no data_ok -> out_sram_req=0 with requests pending. A data_ok in cycle N re-enables out_sram_req in cycle N+1 (not N). Count returns 4->3->4.
- Wrap and concurrent push/pop: 10 alternating requests with data_ok lagging 2 cycles -> every response goes to the correct port and count never exceeds 2.
- Reset mid-flight: resetn low with 2 outstanding -> all outputs 0 immediately. After release, a stray out_sram_data_ok sets err_unexp_ok=1 and produces no data_ok pulse.
